// File: rtl/sa_drain.sv
// sa_drain: snapshots an N x N systolic-array accumulator matrix and streams
// it out row-major over a valid/ready interface, one element per transfer.
// Optional build macro SA_DRAIN_SAT_EN: saturate each element to OUT_W bits
// instead of truncating (two's-complement wrap) to the low OUT_W bits.
//
// state | meaning
// IDLE  | no snapshot held; start loads a new snapshot
// SEND  | snapshot held; streaming elements, counter = next index to send
module sa_drain #(
  parameter int N     = 2,
  parameter int ACC   = 32,
  parameter int OUT_W = 16,
  localparam int NE    = N * N,
  localparam int IDX_W = (NE > 1) ? $clog2(NE) : 1
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  start,
  input  logic signed [N-1:0][N-1:0][ACC-1:0]   acc_in,
  output logic                                  busy,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic signed [OUT_W-1:0]               out_data,
  output logic [IDX_W-1:0]                      out_idx,
  output logic                                  out_last,
  output logic                                  done,
  output logic                                  drop_err
);

  typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NE - 1);

`ifdef SA_DRAIN_SAT_EN
  localparam logic signed [ACC-1:0] SAT_MAX = {{(ACC-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [ACC-1:0] SAT_MIN = {{(ACC-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};
`endif

  state_t                  state, state_nxt;
  logic [IDX_W-1:0]        cnt;
  logic signed [ACC-1:0]   snap [NE];
  logic signed [ACC-1:0]   elem;
  logic signed [OUT_W-1:0] elem_conv;
  logic                    load, xfer, last_xfer;

  // Next-state decode: IDLE accepts start, SEND advances on each accepted transfer.
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    xfer      = 1'b0;
    last_xfer = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load      = 1'b1;
          state_nxt = SEND;
        end
      end
      SEND: begin
        xfer = out_ready;
        if (out_ready && (cnt == LAST_IDX)) begin
          last_xfer = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State, element counter, done pulse and sticky drop flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      done     <= 1'b0;
      drop_err <= 1'b0;
    end else begin
      state <= state_nxt;
      done  <= last_xfer;
      if (load) begin
        cnt <= '0;
      end else if (xfer) begin
        cnt <= cnt + 1'b1;
      end
      if ((state == SEND) && start) begin
        drop_err <= 1'b1;
      end
    end
  end

  // Snapshot buffer; left unreset since it is only visible while streaming.
  always_ff @(posedge clk) begin
    if (load) begin
      for (int r = 0; r < N; r++) begin
        for (int c = 0; c < N; c++) begin
          snap[r*N + c] <= acc_in[r][c];
        end
      end
    end
  end

  // Element select and narrowing to the output width.
  always_comb begin
    elem = snap[cnt];
`ifdef SA_DRAIN_SAT_EN
    if (elem > SAT_MAX) begin
      elem_conv = OUT_W'(SAT_MAX);
    end else if (elem < SAT_MIN) begin
      elem_conv = OUT_W'(SAT_MIN);
    end else begin
      elem_conv = OUT_W'(elem);
    end
`else
    elem_conv = OUT_W'(elem);
`endif
  end

  // Stream outputs are forced to zero outside SEND so stale snapshot data never leaks.
  always_comb begin
    busy      = (state == SEND);
    out_valid = (state == SEND);
    out_data  = (state == SEND) ? elem_conv : '0;
    out_idx   = (state == SEND) ? cnt : '0;
    out_last  = (state == SEND) && (cnt == LAST_IDX);
  end

endmodule

// File: tb/tb_sa_drain.sv
// Directed bench for sa_drain (N=2, ACC=32, OUT_W=16).
module tb_sa_drain;

  logic                        clk = 1'b0;
  logic                        rst;
  logic                        start;
  logic signed [1:0][1:0][31:0] acc_in;
  logic                        busy;
  logic                        out_valid;
  logic                        out_ready;
  logic signed [15:0]          out_data;
  logic [1:0]                  out_idx;
  logic                        out_last;
  logic                        done;
  logic                        drop_err;

  int vec = 0;
  int err = 0;

  sa_drain #(.N(2), .ACC(32), .OUT_W(16)) dut (
    .clk(clk), .rst(rst), .start(start), .acc_in(acc_in),
    .busy(busy), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_idx(out_idx), .out_last(out_last),
    .done(done), .drop_err(drop_err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_acc(input int a, input int b, input int c, input int d);
    acc_in[0][0] = a;
    acc_in[0][1] = b;
    acc_in[1][0] = c;
    acc_in[1][1] = d;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    start = 1'b0;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; out_ready = 1'b1;
    set_acc(5, 6, 7, 8);
    step();
    step();
    vec++; if ({busy, out_valid, out_last, done, drop_err} !== 5'b0) begin
      err++; $display("FAIL reset_flags got %b want 00000", {busy, out_valid, out_last, done, drop_err});
    end
    vec++; if (out_data !== 16'sd0 || out_idx !== 2'd0) begin
      err++; $display("FAIL reset_data got data=%0d idx=%0d want 0/0", out_data, out_idx);
    end
    rst = 1'b0; start = 1'b0;
    step();
    step();
    vec++; if (out_valid !== 1'b0 || busy !== 1'b0) begin
      err++; $display("FAIL idle_ready got valid=%b busy=%b want 0/0", out_valid, busy);
    end
  endtask

  task automatic test_basic();
    int exp_d [4] = '{15, 18, 20, 24};
    set_acc(15, 18, 20, 24);
    out_ready = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      vec++; if (out_valid !== 1'b1 || busy !== 1'b1 || done !== 1'b0) begin
        err++; $display("FAIL basic_valid k=%0d got valid=%b busy=%b done=%b want 1/1/0", k, out_valid, busy, done);
      end
      vec++; if (out_idx !== 2'(k) || out_data !== 16'(exp_d[k]) || out_last !== (k == 3)) begin
        err++; $display("FAIL basic_elem k=%0d got idx=%0d data=%0d last=%b want %0d/%0d/%b",
                        k, out_idx, out_data, out_last, k, exp_d[k], k == 3);
      end
      step();
    end
    vec++; if (done !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
      err++; $display("FAIL basic_done got done=%b valid=%b busy=%b want 1/0/0", done, out_valid, busy);
    end
    step();
    vec++; if (done !== 1'b0) begin
      err++; $display("FAIL basic_done_pulse got done=%b want 0", done);
    end
  endtask

  task automatic test_stall();
    int exp_d [4] = '{15, 18, 20, 24};
    bit pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    int exp_idx = 0;
    int cyc = 0;
    set_acc(15, 18, 20, 24);
    out_ready = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    while (exp_idx < 4 && cyc < 40) begin
      vec++; if (out_valid !== 1'b1 || out_idx !== 2'(exp_idx) || out_data !== 16'(exp_d[exp_idx])) begin
        err++; $display("FAIL stall_elem cyc=%0d got valid=%b idx=%0d data=%0d want 1/%0d/%0d",
                        cyc, out_valid, out_idx, out_data, exp_idx, exp_d[exp_idx]);
      end
      out_ready = pat[cyc % 4];
      if (out_ready) exp_idx++;
      cyc++;
      step();
    end
    vec++; if (exp_idx != 4) begin
      err++; $display("FAIL stall_timeout got %0d transfers want 4", exp_idx);
    end
    vec++; if (done !== 1'b1 || out_valid !== 1'b0) begin
      err++; $display("FAIL stall_done got done=%b valid=%b want 1/0", done, out_valid);
    end
    out_ready = 1'b1;
    step();
  endtask

  task automatic test_drop();
    int exp_d [4] = '{15, 18, 20, 24};
    set_acc(15, 18, 20, 24);
    out_ready = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      vec++; if (out_valid !== 1'b1 || out_idx !== 2'(k) || out_data !== 16'(exp_d[k])) begin
        err++; $display("FAIL drop_elem k=%0d got valid=%b idx=%0d data=%0d want 1/%0d/%0d",
                        k, out_valid, out_idx, out_data, k, exp_d[k]);
      end
      if (k == 1) begin
        start = 1'b1;
        set_acc(99, 99, 99, 99);
      end else begin
        start = 1'b0;
      end
      step();
      if (k == 1) begin
        vec++; if (drop_err !== 1'b1) begin
          err++; $display("FAIL drop_set got drop_err=%b want 1", drop_err);
        end
      end
    end
    vec++; if (done !== 1'b1 || drop_err !== 1'b1) begin
      err++; $display("FAIL drop_done got done=%b drop_err=%b want 1/1", done, drop_err);
    end
    step();
    step();
    vec++; if (drop_err !== 1'b1 || out_valid !== 1'b0) begin
      err++; $display("FAIL drop_sticky got drop_err=%b valid=%b want 1/0", drop_err, out_valid);
    end
    do_reset();
    #1;
    vec++; if (drop_err !== 1'b0) begin
      err++; $display("FAIL drop_clear got drop_err=%b want 0", drop_err);
    end
  endtask

  task automatic test_conv();
`ifdef SA_DRAIN_SAT_EN
    int exp_d [4] = '{32767, -32768, 3, -4};
`else
    int exp_d [4] = '{4464, -4464, 3, -4};
`endif
    set_acc(70000, -70000, 3, -4);
    out_ready = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      vec++; if (out_idx !== 2'(k) || out_data !== 16'(exp_d[k])) begin
        err++; $display("FAIL conv_elem k=%0d got idx=%0d data=%0d want %0d/%0d",
                        k, out_idx, out_data, k, exp_d[k]);
      end
      step();
    end
    step();
  endtask

  task automatic test_rst_mid();
    int exp_d [4] = '{15, 18, 20, 24};
    set_acc(15, 18, 20, 24);
    out_ready = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    vec++; if (out_idx !== 2'd2) begin
      err++; $display("FAIL rstmid_pos got idx=%0d want 2", out_idx);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    vec++; if (out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || out_idx !== 2'd0) begin
      err++; $display("FAIL rstmid_abort got valid=%b busy=%b done=%b idx=%0d want 0/0/0/0",
                      out_valid, busy, done, out_idx);
    end
    step();
    vec++; if (done !== 1'b0) begin
      err++; $display("FAIL rstmid_nodone got done=%b want 0", done);
    end
    start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      vec++; if (out_valid !== 1'b1 || out_idx !== 2'(k) || out_data !== 16'(exp_d[k])) begin
        err++; $display("FAIL rstmid_redrain k=%0d got valid=%b idx=%0d data=%0d want 1/%0d/%0d",
                        k, out_valid, out_idx, out_data, k, exp_d[k]);
      end
      step();
    end
    step();
  endtask

  task automatic test_back_to_back();
    int exp_a [4] = '{15, 18, 20, 24};
    int exp_b [4] = '{1, 2, 3, 4};
    set_acc(15, 18, 20, 24);
    out_ready = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      vec++; if (out_idx !== 2'(k) || out_data !== 16'(exp_a[k])) begin
        err++; $display("FAIL b2b_first k=%0d got idx=%0d data=%0d want %0d/%0d",
                        k, out_idx, out_data, k, exp_a[k]);
      end
      step();
    end
    vec++; if (done !== 1'b1) begin
      err++; $display("FAIL b2b_done got done=%b want 1", done);
    end
    start = 1'b1;
    set_acc(1, 2, 3, 4);
    step();
    start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      vec++; if (out_valid !== 1'b1 || out_idx !== 2'(k) || out_data !== 16'(exp_b[k]) || out_last !== (k == 3)) begin
        err++; $display("FAIL b2b_second k=%0d got valid=%b idx=%0d data=%0d last=%b want 1/%0d/%0d/%b",
                        k, out_valid, out_idx, out_data, out_last, k, exp_b[k], k == 3);
      end
      step();
    end
    vec++; if (done !== 1'b1 || drop_err !== 1'b0) begin
      err++; $display("FAIL b2b_end got done=%b drop_err=%b want 1/0", done, drop_err);
    end
    step();
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; out_ready = 1'b0;
    set_acc(0, 0, 0, 0);
    test_reset();
    test_basic();
    test_stall();
    test_drop();
    test_conv();
    test_rst_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end

endmodule

// File: doc/sa_drain.md
SA_DRAIN -- requirements
Module: sa_drain

Interface
- REQ-001 Parameter N, default 2: systolic array dimension (N x N accumulators).
- REQ-002 Parameter ACC, default 32: accumulator width in bits, signed.
- REQ-003 Parameter OUT_W, default 16: output stream data width in bits, signed, OUT_W <= ACC.
- REQ-004 clk  input  1: single clock, all state updates on rising edge.
- REQ-005 rst  input  1: synchronous, active-high reset.
- REQ-006 start  input  1: one-cycle request to snapshot and drain the array accumulators.
- REQ-007 acc_in  input  N x N x ACC signed: accumulator matrix from the systolic array, index [row][col].
- REQ-008 busy  output  1: high while a snapshot is held and not fully drained.
- REQ-009 out_valid  output  1: stream element valid.
- REQ-010 out_ready  input  1: downstream accepts element.
- REQ-011 out_data  output  OUT_W signed: current element value.
- REQ-012 out_idx  output  clog2(N*N): row-major element index (row*N + col).
- REQ-013 out_last  output  1: high with the element at index N*N-1.
- REQ-014 done  output  1: one-cycle pulse after the final element is transferred.
- REQ-015 drop_err  output  1: sticky flag, a start was ignored while busy.

Function
- REQ-016 FSM states: IDLE, SEND; IDLE is the reset state.
- REQ-017 IDLE with start=1: register all N*N acc_in values into an internal snapshot buffer, clear element counter to 0, enter SEND on the next edge.
- REQ-018 Latency: start sampled at edge t -> out_valid=1 with out_idx=0 from edge t onward (first cycle after t).
- REQ-019 SEND: out_valid=1, out_data/out_idx/out_last derived from snapshot[counter]; busy=1.
- REQ-020 Transfer occurs only on a cycle with out_valid=1 and out_ready=1; counter increments by 1 per transfer.
- REQ-021 With out_valid=1 and out_ready=0, out_data, out_idx, out_last hold stable until transfer.
- REQ-022 Transfer of index N*N-1: next state IDLE, done=1 for exactly that following cycle, busy=0, out_valid=0.
- REQ-023 start is accepted in the same cycle done=1 (back-to-back drains, no bubble beyond the done cycle).
- REQ-024 start while in SEND: ignored, snapshot and counter unchanged, drop_err set to 1.
- REQ-025 drop_err stays 1 until rst; it is not cleared by done or by a new start.
- REQ-026 acc_in changes after the snapshot edge have no effect on the current drain.
- REQ-027 out_ready while out_valid=0 has no effect; no element is skipped or repeated.
- REQ-028 OUT_W < ACC conversion per REQ-033/034; OUT_W == ACC passes values unchanged.

Reset
- REQ-029 rst=1 at a rising edge: state IDLE, counter 0, busy=0, out_valid=0, out_last=0, done=0, drop_err=0, out_data=0, out_idx=0.
- REQ-030 rst mid-drain aborts the drain; no done pulse is produced for the aborted drain.
- REQ-031 rst has priority over start in the same cycle.
- REQ-032 Snapshot buffer contents need not be reset; they are never visible while out_valid=0.

Configuration
- REQ-033 With macro SA_DRAIN_SAT_EN defined: each element saturates to [-2^(OUT_W-1), 2^(OUT_W-1)-1] before output.
- REQ-034 Without SA_DRAIN_SAT_EN: each element is truncated to its low OUT_W bits (two's-complement wrap).

Verification
- REQ-035 N=2, acc_in={{15,18},{20,24}}, start pulse, out_ready=1 -> idx 0..3 data 15,18,20,24 on four consecutive cycles, out_last on idx 3, done next cycle.
- REQ-036 Same data, out_ready toggling 1,0,0,1,... -> data/idx held during stalls, order 15,18,20,24 preserved, exactly 4 transfers.
- REQ-037 start pulse again at idx 1 of a drain -> drop_err=1 and stays 1, drain completes unchanged; change acc_in to all 99 during drain -> outputs unchanged.
- REQ-038 acc_in[0][0]=70000, acc_in[0][1]=-70000 -> with SA_DRAIN_SAT_EN: 32767, -32768; without: 4464, -4464.
- REQ-039 rst=1 at idx 2 -> next cycle out_valid=0, busy=0, no done; new start afterwards drains from idx 0.
- REQ-040 start asserted in the done cycle with new acc_in={{1,2},{3,4}} -> second drain 1,2,3,4 begins next cycle, drop_err stays 0.
